// File: rtl/cnn_pkg.sv
// Shared types and the requantize/ReLU helper for the CNN datapath blocks.
package cnn_pkg;

  localparam int CNN_WORD_W = 8;
  localparam int CNN_ACC_W  = 2*CNN_WORD_W + 5;

  typedef logic        [CNN_WORD_W-1:0] pixel_t;
  typedef logic signed [CNN_WORD_W-1:0] weight_t;
  typedef logic signed [CNN_ACC_W-1:0]  acc_t;

  // Arithmetic shift, then clamp into the unsigned pixel range (negative -> 0).
  function automatic pixel_t clamp_relu(acc_t acc, int shift);
    acc_t shifted;
    shifted = acc >>> shift;
    if (shifted < 0)
      return '0;
    else if (shifted > acc_t'((1 << CNN_WORD_W) - 1))
      return '1;
    else
      return shifted[CNN_WORD_W-1:0];
  endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Column/row position tracker for the streamed windows. Decides whether the
// window accepted this cycle lies fully inside the image, and whether it is
// the final window of the frame.
module conv_pos_counter
  import cnn_pkg::*;
#(
  parameter int K        = 3,
  parameter int ROW_SIZE = 540,
  parameter int NUM_ROWS = 540
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic win_vld,
  output logic win_last
);

  localparam int CW = $clog2(ROW_SIZE);
  localparam int RW = $clog2(NUM_ROWS);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Next position: step only on an accepted window, wrapping at row and frame ends
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (col_q == CW'(ROW_SIZE-1)) begin
        col_d = '0;
        if (row_q == RW'(NUM_ROWS-1))
          row_d = '0;
        else
          row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Position state, restarted at the frame origin on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Qualification uses the position before this cycle's increment
  assign win_vld  = in_valid && (col_q >= CW'(K-1)) && (row_q >= RW'(K-1));
  assign win_last = (row_q == RW'(NUM_ROWS-1)) && (col_q == CW'(ROW_SIZE-1));

endmodule

// File: rtl/conv3x3_engine.sv
// KxK convolution engine: programmable signed kernel, three-stage MAC
// pipeline (products, row sums, bias + requantize + ReLU) with valid/last
// tags travelling alongside the data.
module conv3x3_engine
  import cnn_pkg::*;
#(
  parameter int WORD_SIZE   = 8,
  parameter int BUFFER_SIZE = 3,
  parameter int ROW_SIZE    = 540,
  parameter int NUM_ROWS    = 540,
  parameter int SHIFT       = 0,
  parameter int ACC_W       = 2*WORD_SIZE + 5
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 in_valid,
  input  logic [BUFFER_SIZE-1:0][BUFFER_SIZE-1:0][WORD_SIZE-1:0] window,
  input  logic                                                 wt_we,
  input  logic [$clog2(BUFFER_SIZE*BUFFER_SIZE)-1:0]           wt_addr,
  input  logic [WORD_SIZE-1:0]                                 wt_data,
  input  logic [ACC_W-1:0]                                     bias,
  output logic                                                 out_valid,
  output logic [WORD_SIZE-1:0]                                 out_pixel,
  output logic                                                 out_last
);

  localparam int K      = BUFFER_SIZE;
  localparam int NW     = K*K;
  localparam int AW     = $clog2(NW);
  localparam int PROD_W = 2*WORD_SIZE + 1;

  logic win_vld, win_last;

  conv_pos_counter #(
    .K        (K),
    .ROW_SIZE (ROW_SIZE),
    .NUM_ROWS (NUM_ROWS)
  ) u_pos (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .win_vld  (win_vld),
    .win_last (win_last)
  );

  logic signed [WORD_SIZE-1:0] wt_q [NW];
  logic signed [WORD_SIZE-1:0] wt_d [NW];

  logic vld_p1_q, vld_p1_d, last_p1_q, last_p1_d;
  logic vld_p2_q, vld_p2_d, last_p2_q, last_p2_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [WORD_SIZE-1:0] out_pixel_q, out_pixel_d;

  logic signed [PROD_W-1:0] prod_p1_q   [K][K];
  logic signed [PROD_W-1:0] prod_p1_d   [K][K];
  logic signed [ACC_W-1:0]  rowsum_p2_q [K];
  logic signed [ACC_W-1:0]  rowsum_p2_d [K];
  logic signed [ACC_W-1:0]  total_p3;

  // Weight file update; an address past the last tap matches no entry
  always_comb begin
    for (int n = 0; n < NW; n++) begin
      wt_d[n] = wt_q[n];
      if (wt_we && (wt_addr == AW'(n)))
        wt_d[n] = $signed(wt_data);
    end
  end

  // Stage 1: one product per tap, pixel zero-extended so it stays non-negative
  always_comb begin
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        prod_p1_d[i][j] = PROD_W'($signed({1'b0, window[i][j]})) * PROD_W'(wt_q[i*K+j]);
  end

  // Stage 2: reduce each kernel row to a single partial sum
  always_comb begin
    for (int i = 0; i < K; i++) begin
      rowsum_p2_d[i] = '0;
      for (int j = 0; j < K; j++)
        rowsum_p2_d[i] = rowsum_p2_d[i] + ACC_W'(prod_p1_q[i][j]);
    end
  end

  // Stage 3: add bias, requantize and clamp; hold the pixel on bubbles
  always_comb begin
    total_p3 = $signed(bias);
    for (int i = 0; i < K; i++)
      total_p3 = total_p3 + rowsum_p2_q[i];
    out_pixel_d = vld_p2_q ? WORD_SIZE'(clamp_relu(acc_t'(total_p3), SHIFT)) : out_pixel_q;
  end

  // Valid/last tags advance one stage per cycle regardless of in_valid
  always_comb begin
    vld_p1_d    = win_vld;
    last_p1_d   = win_vld & win_last;
    vld_p2_d    = vld_p1_q;
    last_p2_d   = last_p1_q;
    out_valid_d = vld_p2_q;
    out_last_d  = last_p2_q;
  end

  // Control, weights and output: async clear drops every in-flight result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NW; n++)
        wt_q[n] <= '0;
      vld_p1_q    <= 1'b0;
      last_p1_q   <= 1'b0;
      vld_p2_q    <= 1'b0;
      last_p2_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pixel_q <= '0;
    end else begin
      wt_q        <= wt_d;
      vld_p1_q    <= vld_p1_d;
      last_p1_q   <= last_p1_d;
      vld_p2_q    <= vld_p2_d;
      last_p2_q   <= last_p2_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_pixel_q <= out_pixel_d;
    end
  end

  // Datapath registers carry no reset; the valid tags say what is meaningful
  always_ff @(posedge clk) begin
    prod_p1_q   <= prod_p1_d;
    rowsum_p2_q <= rowsum_p2_d;
  end

  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv3x3_engine.sv
// Bench for conv3x3_engine on a small 5x4 image. Two instances differ only
// in SHIFT (0 and 2). A behavioural model computes every expected output.
module tb_conv3x3_engine;

  localparam int W  = 8;
  localparam int K  = 3;
  localparam int RS = 5;
  localparam int NR = 4;
  localparam int AW = 2*W + 5;

  typedef struct {
    int due;
    int p0;
    int p2;
    int last;
  } exp_t;

  logic                        clk, rst_n, in_valid, wt_we;
  logic [K-1:0][K-1:0][W-1:0]  win;
  logic [3:0]                  wt_addr;
  logic [W-1:0]                wt_data;
  logic [AW-1:0]               bias;
  logic                        ov_a, ol_a, ov_b, ol_b;
  logic [W-1:0]                op_a, op_b;

  int   n_checks, n_fail, edge_cnt, n_last, mcol, mrow, hold_a, hold_b;
  int   mw [9];
  exp_t q [$];
  int   vld_vals [$];
  int   vld_edges [$];

  conv3x3_engine #(.WORD_SIZE(W), .BUFFER_SIZE(K), .ROW_SIZE(RS), .NUM_ROWS(NR), .SHIFT(0)) dut_a (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .window(win), .wt_we(wt_we),
    .wt_addr(wt_addr), .wt_data(wt_data), .bias(bias),
    .out_valid(ov_a), .out_pixel(op_a), .out_last(ol_a));

  conv3x3_engine #(.WORD_SIZE(W), .BUFFER_SIZE(K), .ROW_SIZE(RS), .NUM_ROWS(NR), .SHIFT(2)) dut_b (
    .clk(clk), .rst(rst_n), .in_valid(in_valid), .window(win), .wt_we(wt_we),
    .wt_addr(wt_addr), .wt_data(wt_data), .bias(bias),
    .out_valid(ov_b), .out_pixel(op_b), .out_last(ol_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clampf(int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: frame position, kernel and the expected-output queue
  task automatic model_loop();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        mcol = 0;
        mrow = 0;
        foreach (mw[n]) mw[n] = 0;
      end else begin
        edge_cnt++;
        if (in_valid) begin
          if (mcol >= K-1 && mrow >= K-1) begin
            int   s;
            exp_t e;
            s = int'($signed(bias));
            for (int i = 0; i < K; i++)
              for (int j = 0; j < K; j++)
                s += int'(win[i][j]) * mw[i*K+j];
            e.due  = edge_cnt + 2;
            e.p0   = clampf(s);
            e.p2   = clampf(s >>> 2);
            e.last = (mrow == NR-1 && mcol == RS-1) ? 1 : 0;
            q.push_back(e);
          end
          if (mcol == RS-1) begin
            mcol = 0;
            mrow = (mrow == NR-1) ? 0 : mrow + 1;
          end else begin
            mcol++;
          end
        end
        if (wt_we && wt_addr < 4'd9) mw[wt_addr] = int'($signed(wt_data));
      end
    end
  endtask

  // Compare every cycle, away from the active edge
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_a = 0;
        hold_b = 0;
      end
      if (q.size() > 0 && q[0].due == edge_cnt) begin
        check("out_valid", int'(ov_a), 1);
        check("out_valid_s2", int'(ov_b), 1);
        check("out_pixel", int'(op_a), q[0].p0);
        check("out_pixel_s2", int'(op_b), q[0].p2);
        check("out_last", int'(ol_a), q[0].last);
        check("out_last_s2", int'(ol_b), q[0].last);
        hold_a = q[0].p0;
        hold_b = q[0].p2;
        void'(q.pop_front());
      end else begin
        check("idle_valid", int'(ov_a), 0);
        check("idle_valid_s2", int'(ov_b), 0);
        check("hold_pixel", int'(op_a), hold_a);
        check("hold_pixel_s2", int'(op_b), hold_b);
        check("idle_last", int'(ol_a), 0);
        check("idle_last_s2", int'(ol_b), 0);
      end
      if (ov_a) begin
        vld_vals.push_back(int'(op_a));
        vld_edges.push_back(edge_cnt);
        if (ol_a) n_last++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
    in_valid = 1'b0;
    wt_we    = 1'b1;
    wt_addr  = a;
    wt_data  = d;
    step();
    wt_we    = 1'b0;
  endtask

  task automatic set_win(input int pix, input int center);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        win[i][j] = W'(pix);
    win[1][1] = W'(center);
  endtask

  task automatic stream(input int n, input int pix, input int center, output int start);
    start = 0;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      set_win(pix, center);
      step();
      if (k == 0) start = edge_cnt;
    end
    in_valid = 1'b0;
  endtask

  task automatic last_val(input string name, input int base, input int exp);
    if (vld_vals.size() > base)
      check(name, vld_vals[vld_vals.size()-1], exp);
    else
      check({name, "_present"}, vld_vals.size() - base, 1);
  endtask

  initial begin
    int base, lbase, start;
    rst_n = 1'b0; in_valid = 1'b0; wt_we = 1'b0; wt_addr = '0; wt_data = '0;
    bias = '0; win = '0;
    n_checks = 0; n_fail = 0; edge_cnt = 0; n_last = 0; mcol = 0; mrow = 0;
    hold_a = 0; hold_b = 0;
    foreach (mw[n]) mw[n] = 0;
    fork
      model_loop();
      monitor_loop();
    join_none

    step(); step();
    check("reset_out_valid", int'(ov_a), 0);
    check("reset_out_pixel", int'(op_a), 0);
    check("reset_out_last", int'(ol_a), 0);
    rst_n = 1'b1;
    step();

    // Identity kernel over two frames; out-of-range write must be ignored
    wr(4'd4, 8'd1);
    wr(4'd13, 8'h80);
    base = vld_vals.size(); lbase = n_last;
    stream(40, 200, 77, start);
    idle(4);
    check("id_count", vld_vals.size() - base, 12);
    check("id_lasts", n_last - lbase, 2);
    if (vld_vals.size() > base) begin
      check("id_value", vld_vals[base], 77);
      check("id_latency", vld_edges[base] - start, 14);
    end
    last_val("id_value_end", base, 77);

    // Saturation: 9 * 255 = 2295 clamps to 255
    for (int n = 0; n < 9; n++) wr(4'(n), 8'd1);
    wr(4'd9, 8'd5);
    base = vld_vals.size();
    stream(20, 255, 255, start);
    idle(4);
    check("sat_count", vld_vals.size() - base, 6);
    last_val("sat_value", base, 255);
    check("sat_value_s2", int'(op_b), 255);

    // ReLU: negative sum clamps to 0
    for (int n = 0; n < 9; n++) wr(4'(n), 8'hFF);
    base = vld_vals.size();
    stream(20, 10, 10, start);
    idle(4);
    check("relu_count", vld_vals.size() - base, 6);
    last_val("relu_value", base, 0);

    // Bias and shift: 90 - 10 = 80, and 80 >>> 2 = 20
    for (int n = 0; n < 9; n++) wr(4'(n), 8'd1);
    bias = AW'(-10);
    base = vld_vals.size();
    stream(20, 10, 10, start);
    idle(4);
    last_val("bias_value", base, 80);
    check("bias_shift_value", int'(op_b), 20);
    bias = '0;

    // Bubbles with a weight change between the 4th and 5th valid windows
    for (int n = 0; n < 9; n++) wr(4'(n), 8'd0);
    wr(4'd4, 8'd1);
    base = vld_vals.size(); lbase = n_last;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      set_win(5, 10 + k);
      step();
      in_valid = 1'b0;
      if (k == 17) wr(4'd4, 8'd2);
      else step();
    end
    idle(4);
    check("bub_count", vld_vals.size() - base, 6);
    check("bub_lasts", n_last - lbase, 1);
    if (vld_vals.size() >= base + 5) begin
      check("bub_old_weight", vld_vals[base+3], 27);
      check("bub_new_weight", vld_vals[base+4], 56);
      check("bub_spacing", vld_edges[base+1] - vld_edges[base], 2);
    end

    // Reset mid-frame with results in flight
    stream(15, 30, 40, start);
    check("pre_rst_valid", int'(ov_a), 1);
    check("pre_rst_pixel", int'(op_a), 80);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", int'(ov_a), 0);
    check("rst_async_valid_s2", int'(ov_b), 0);
    check("rst_async_pixel", int'(op_a), 0);
    step(); step();
    rst_n = 1'b1;
    base = vld_vals.size(); lbase = n_last;
    stream(20, 50, 50, start);
    idle(4);
    check("post_rst_count", vld_vals.size() - base, 6);
    check("post_rst_lasts", n_last - lbase, 1);
    if (vld_vals.size() > base)
      check("post_rst_latency", vld_edges[base] - start, 14);
    last_val("post_rst_zero_wts", base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
